bus_target: RTL and testbench

BUS_TARGET -- requirements
Module: bus_target

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_sync2.sv | 21 ++
 rtl/bus_target.sv | 115 +++++++++++
 tb/tb_bus_target.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the bus_target slice: bus phases, FSM states and
// the expected-phase tracker values.
package bus_pkg;

   localparam logic [1:0] PH_ADDR_LO = 2'b00;
   localparam logic [1:0] PH_ADDR_HI = 2'b01;
   localparam logic [1:0] PH_READ    = 2'b10;
   localparam logic [1:0] PH_WRITE   = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_MEM  = 2'b01;
   localparam logic [1:0] ST_ACK  = 2'b10;

   // What the phase-order tracker expects next; EXP_DATA accepts 10 or 11.
   localparam logic [1:0] EXP_LO   = 2'b00;
   localparam logic [1:0] EXP_HI   = 2'b01;
   localparam logic [1:0] EXP_DATA = 2'b10;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchronizer for the asynchronous initiator request.
module bus_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bus_target.sv
// 4-phase handshake bus target: address/data phases mapped onto a local
// level-based memory request interface, with phase-order checking.
module bus_target
   import bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_handshake_req,
   output logic        bus_handshake_ack,
   input  logic [1:0]  bus_state,
   input  logic [7:0]  bus_data_in,
   output logic [7:0]  bus_data_out,
   output logic        bus_output_enable,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        seq_error
);

   logic       req_s;
   logic [1:0] state;
   logic [1:0] exp_ph;
   logic [7:0] rd_reg;
   logic       phase_ok;

   bus_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus_handshake_req),
      .q   (req_s)
   );

   always_comb begin
      case (exp_ph)
         EXP_LO:  phase_ok = (bus_state == PH_ADDR_LO);
         EXP_HI:  phase_ok = (bus_state == PH_ADDR_HI);
         default: phase_ok = bus_state[1];
      endcase
   end

   assign bus_data_out = rd_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         exp_ph            <= EXP_LO;
         bus_handshake_ack <= 1'b0;
         bus_output_enable <= 1'b0;
         mem_read          <= 1'b0;
         mem_write         <= 1'b0;
         mem_addr          <= 16'h0000;
         mem_wdata         <= 8'h00;
         rd_reg            <= 8'h00;
         seq_error         <= 1'b0;
      end else begin
         seq_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_s) begin
                  // Out-of-order phases are flagged but still executed.
                  seq_error <= ~phase_ok;
                  case (bus_state)
                     PH_ADDR_LO: begin
                        mem_addr[7:0]     <= bus_data_in;
                        exp_ph            <= EXP_HI;
                        bus_handshake_ack <= 1'b1;
                        state             <= ST_ACK;
                     end
                     PH_ADDR_HI: begin
                        mem_addr[15:8]    <= bus_data_in;
                        exp_ph            <= EXP_DATA;
                        bus_handshake_ack <= 1'b1;
                        state             <= ST_ACK;
                     end
                     PH_READ: begin
                        mem_read <= 1'b1;
                        exp_ph   <= EXP_LO;
                        state    <= ST_MEM;
                     end
                     default: begin
                        mem_wdata <= bus_data_in;
                        mem_write <= 1'b1;
                        exp_ph    <= EXP_LO;
                        state     <= ST_MEM;
                     end
                  endcase
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  if (mem_read) begin
                     rd_reg            <= mem_rdata;
                     bus_output_enable <= 1'b1;
                  end
                  mem_read          <= 1'b0;
                  mem_write         <= 1'b0;
                  bus_handshake_ack <= 1'b1;
                  state             <= ST_ACK;
               end
            end
            default: begin
               if (!req_s) begin
                  bus_handshake_ack <= 1'b0;
                  bus_output_enable <= 1'b0;
                  state             <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_target.sv
// Scoreboard bench for bus_target: a phase model pushes expected results,
// a negedge monitor pops and compares them on every ack rise.
module tb_bus_target;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        ack;
   logic [1:0]  bus_state;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic        oe;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic        seq_error;

   typedef struct {
      logic [1:0]  ph;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rd;
      logic        err;
      int          lat;
      int          req_cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [7:0]  rdata_val = 8'h00;
   int          ack_rises = 0;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   logic [1:0]  m_exp;

   bus_target dut (
      .clk               (clk),
      .rst               (rst),
      .bus_handshake_req (req),
      .bus_handshake_ack (ack),
      .bus_state         (bus_state),
      .bus_data_in       (bus_data_in),
      .bus_data_out      (bus_data_out),
      .bus_output_enable (oe),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .mem_ready         (mem_ready),
      .seq_error         (seq_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [1:0] ph, input logic [7:0] d,
                                  input int l, input logic [7:0] rd);
      exp_t e;
      e.err = !((m_exp == 2'd0 && ph == 2'd0) || (m_exp == 2'd1 && ph == 2'd1) ||
                (m_exp == 2'd2 && ph[1]));
      case (ph)
         2'd0: begin m_addr[7:0]  = d; m_exp = 2'd1; end
         2'd1: begin m_addr[15:8] = d; m_exp = 2'd2; end
         2'd2: m_exp = 2'd0;
         default: begin m_wdata = d; m_exp = 2'd0; end
      endcase
      e.ph = ph; e.addr = m_addr; e.wdata = m_wdata; e.rd = rd;
      e.lat = l; e.req_cyc = 0;
      return e;
   endfunction

   task automatic wait_ack(input logic v, input string tag);
      int n = 0;
      while (ack !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(ack), 32'(v));
   endtask

   task automatic finish_handshake();
      int k;
      wait_ack(1'b1, "ack_rise");
      req = 1'b0;
      k = cyc;
      wait_ack(1'b0, "ack_fall");
      chk("ack_fall_lat", cyc, k + 3);
   endtask

   task automatic do_phase(input logic [1:0] ph, input logic [7:0] d,
                           input int l, input logic [7:0] rd);
      exp_t e;
      @(negedge clk);
      lat = l;
      rdata_val = rd;
      e = model(ph, d, l, rd);
      e.req_cyc = cyc + 1;
      sb.push_back(e);
      bus_state = ph;
      bus_data_in = d;
      req = 1'b1;
      finish_handshake();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      m_addr = 16'h0; m_wdata = 8'h0; m_exp = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Memory responder plus scoreboard monitor, all on the falling edge.
   initial begin : monitor
      int   acc_cnt = 0;
      int   acc_seen = 0;
      int   mlat;
      logic seq_seen = 1'b0;
      logic seq_q = 1'b0;
      logic ack_q = 1'b0;
      exp_t e;
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) acc_cnt++; else acc_cnt = 0;
         mem_ready = (mem_read || mem_write) && (acc_cnt >= lat);
         mem_rdata = rdata_val;
         if (rst) begin
            seq_seen = 1'b0;
            acc_seen = 0;
         end else begin
            if (seq_error) begin
               chk("seq_pulse", 32'(seq_q), 32'(0));
               seq_seen = 1'b1;
            end
            if (mem_read || mem_write) acc_seen++;
            if (ack && !ack_q) begin
               ack_rises++;
               if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
               else begin
                  e = sb.pop_front();
                  mlat = e.ph[1] ? e.lat : 0;
                  chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                  if (e.ph == 2'd3) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                  chk("seq_error", 32'(seq_seen), 32'(e.err));
                  chk("mem_cycles", acc_seen, mlat);
                  chk("ack_lat", cyc, e.req_cyc + 2 + mlat);
                  chk("oe_on", 32'(oe), 32'(e.ph == 2'd2));
                  if (e.ph == 2'd2) chk("rdata", 32'(bus_data_out), 32'(e.rd));
               end
               seq_seen = 1'b0;
               acc_seen = 0;
            end
            if (!ack && ack_q) chk("oe_fall", 32'(oe), 32'(0));
         end
         ack_q = ack;
         seq_q = seq_error;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin : stim
      exp_t e;
      int   base;
      int   n;
      rst = 1'b1; req = 1'b0; bus_state = 2'd0; bus_data_in = 8'h00;
      m_addr = 16'h0; m_wdata = 8'h0; m_exp = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_oe", 32'(oe), 32'(0));
      chk("rst_rw", 32'({mem_read, mem_write}), 32'(0));
      chk("rst_addr", 32'(mem_addr), 32'(0));
      chk("rst_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_dout", 32'(bus_data_out), 32'(0));
      chk("rst_seq", 32'(seq_error), 32'(0));

      // Write 0xA5 to 0x1234, memory ready after 2 cycles.
      base = ack_rises;
      do_phase(2'd0, 8'h34, 1, 8'h00);
      do_phase(2'd1, 8'h12, 1, 8'h00);
      do_phase(2'd3, 8'hA5, 2, 8'h00);
      chk("write_acks", ack_rises - base, 3);

      // Read 0xBEEF, data 0x3C after 5 cycles.
      do_phase(2'd0, 8'hEF, 1, 8'h00);
      do_phase(2'd1, 8'hBE, 1, 8'h00);
      do_phase(2'd2, 8'h00, 5, 8'h3C);

      // Back-to-back reads of 0x00FF; the second is out of order.
      do_phase(2'd0, 8'hFF, 1, 8'h00);
      do_phase(2'd1, 8'h00, 1, 8'h00);
      do_phase(2'd2, 8'h00, 1, 8'h11);
      do_phase(2'd2, 8'h00, 3, 8'h22);

      // High address byte first after reset.
      do_reset();
      do_phase(2'd1, 8'h77, 1, 8'h00);

      // Reset while a read waits in MEM, request held high throughout.
      @(negedge clk);
      lat = 50; rdata_val = 8'h55;
      bus_state = 2'd2; bus_data_in = 8'h00; req = 1'b1;
      n = 0;
      while (!mem_read && n < 50) begin @(negedge clk); n++; end
      chk("rd_pending", 32'(mem_read), 32'(1));
      rst = 1'b1;
      m_addr = 16'h0; m_wdata = 8'h0; m_exp = 2'd0;
      @(negedge clk);
      chk("abort_rw", 32'({mem_read, mem_write}), 32'(0));
      chk("abort_ack", 32'(ack), 32'(0));
      chk("abort_oe", 32'(oe), 32'(0));
      chk("abort_addr", 32'(mem_addr), 32'(0));
      @(negedge clk);
      lat = 3; rdata_val = 8'hC7;
      e = model(2'd2, 8'h00, 3, 8'hC7);
      e.req_cyc = cyc + 1;
      sb.push_back(e);
      rst = 1'b0;
      finish_handshake();

      // Random phase mix.
      for (int i = 0; i < 24; i++)
         do_phase(2'($urandom_range(3)), 8'($urandom_range(255)),
                  int'($urandom_range(4, 1)), 8'($urandom_range(255)));

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
